// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - Frame-sequenced serial pattern recognizer with overlapping match count
module pattern_scan_ctrl #(
    parameter int PAT_W  = 8,
    parameter int PLEN_W = 4,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [PLEN_W-1:0] cfg_plen,
    input  logic [LEN_W-1:0]  cfg_frame,
    input  logic              start,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              match,
    output logic [CNT_W-1:0]  match_count,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  hist_q;
    logic [PAT_W-1:0]  hist_nxt;
    logic [PAT_W-1:0]  plen_mask;
    logic [PLEN_W-1:0] plen_q;
    logic [PLEN_W-1:0] seen_q;
    logic [LEN_W-1:0]  left_q;
    logic              accept;
    logic              cfg_bad;
    logic              start_ok;
    logic              last_bit;
    logic              hit;

    assign in_ready = (state == S_SCAN);
    assign busy     = (state != S_IDLE);
    assign accept   = in_valid & in_ready;
    assign cfg_bad  = (cfg_plen == '0) || ({1'b0, cfg_plen} > (PLEN_W+1)'(PAT_W)) || (cfg_frame == '0);
    assign start_ok = (state == S_IDLE) && start && !cfg_bad;
    assign last_bit = (left_q == LEN_W'(1));
    assign hist_nxt = {hist_q[PAT_W-2:0], in_bit};

    // Only the low plen bits of the history take part in the comparison.
    always_comb begin
        plen_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            plen_mask[i] = (PLEN_W'(i) < plen_q);
        end
    end

    assign hit = accept
              && (({1'b0, seen_q} + (PLEN_W+1)'(1)) >= {1'b0, plen_q})
              && (((hist_nxt ^ pat_q) & plen_mask) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_SCAN;
            S_SCAN:  if (accept && last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q       <= '0;
            plen_q      <= '0;
            left_q      <= '0;
            seen_q      <= '0;
            hist_q      <= '0;
            match       <= 1'b0;
            match_count <= '0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            match   <= hit;
            done    <= accept && last_bit;
            cfg_err <= (state == S_IDLE) && start && cfg_bad;
            if (start_ok) begin
                pat_q       <= cfg_pattern;
                plen_q      <= cfg_plen;
                left_q      <= cfg_frame;
                seen_q      <= '0;
                hist_q      <= '0;
                match_count <= '0;
            end else if (accept) begin
                hist_q <= hist_nxt;
                if (seen_q < plen_q) seen_q <= seen_q + PLEN_W'(1);
                if (left_q != '0) left_q <= left_q - LEN_W'(1);
                if (hit && (match_count != '1)) match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - Randomized self-checking bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_plen;
    logic [15:0] cfg_frame;
    logic        start;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        match;
    logic [7:0]  match_count;
    logic        done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the current frame, in arrival order
    bit         got[$];
    logic [7:0] m_pat;
    int         m_plen;
    int         m_frame;
    int         exp_count;
    int         hit_pos[$];

    pattern_scan_ctrl dut (
        .clk(clk), .reset(reset), .cfg_pattern(cfg_pattern), .cfg_plen(cfg_plen),
        .cfg_frame(cfg_frame), .start(start), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .match(match), .match_count(match_count),
        .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic [7:0] pat, input int plen, input int frame);
        cfg_pattern = pat;
        cfg_plen    = 4'(plen);
        cfg_frame   = 16'(frame);
        start       = 1'b1;
        step();
        start       = 1'b0;
        m_pat = pat; m_plen = plen; m_frame = frame; exp_count = 0;
        got.delete();
        hit_pos.delete();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL start_scan: in_ready=%b busy=%b count=%0d required 1 1 0", in_ready, busy, match_count);
        end
    endtask

    task automatic feed(input bit b, input int idle);
        bit exp_hit;
        for (int k = 0; k < idle; k++) begin
            in_valid = 1'b0;
            step();
            checks++;
            if (match !== 1'b0 || in_ready !== 1'b1 || match_count !== 8'(exp_count)) begin
                errors++;
                $display("FAIL idle_hold: match=%b in_ready=%b count=%0d required 0 1 %0d", match, in_ready, match_count, exp_count);
            end
        end
        in_valid = 1'b1;
        in_bit   = b;
        step();
        in_valid = 1'b0;
        got.push_back(b);
        exp_hit = (got.size() >= m_plen);
        for (int k = 0; k < m_plen && exp_hit; k++) begin
            if (got[got.size() - m_plen + k] != m_pat[m_plen - 1 - k]) exp_hit = 1'b0;
        end
        if (exp_hit) begin
            hit_pos.push_back(got.size());
            if (exp_count < 255) exp_count++;
        end
        checks++;
        if (match !== exp_hit || match_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL bit%0d_match: match=%b count=%0d required %b %0d", got.size(), match, match_count, exp_hit, exp_count);
        end
        checks++;
        if (got.size() == m_frame) begin
            if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL frame_done: done=%b in_ready=%b busy=%b required 1 0 1", done, in_ready, busy);
            end
        end else if (done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame: done=%b in_ready=%b required 0 1", done, in_ready);
        end
    endtask

    task automatic end_frame();
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || match !== 1'b0 || match_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL back_to_idle: done=%b busy=%b in_ready=%b match=%b count=%0d required 0 0 0 0 %0d",
                     done, busy, in_ready, match, match_count, exp_count);
        end
    endtask

    // mode 0: back-to-back, 1: alternating valid, 2: random gaps
    task automatic run_frame(input logic [7:0] pat, input int plen, input int frame, input int mode, input bit bits[$]);
        begin_frame(pat, plen, frame);
        for (int i = 0; i < frame; i++) begin
            feed(bits[i], (mode == 0) ? 0 : (mode == 1) ? ((i == 0) ? 0 : 1) : $urandom_range(0, 2));
        end
        end_frame();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        cfg_pattern = '0; cfg_plen = '0; cfg_frame = '0;
        step(); step();
        reset = 1'b0;
        checks++;
        if ({in_ready, busy, match, done, cfg_err} !== 5'b0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: rdy/busy/match/done/err=%b count=%0d required 00000 0",
                     {in_ready, busy, match, done, cfg_err}, match_count);
        end
    endtask

    task automatic test_t1_back_to_back();
        bit b[$] = '{1, 0, 1, 0, 1, 1, 0, 1};
        run_frame(8'b101, 3, 8, 0, b);
        checks++;
        if (hit_pos.size() != 3 || hit_pos[0] != 3 || hit_pos[1] != 5 || hit_pos[2] != 8 || match_count !== 8'd3) begin
            errors++;
            $display("FAIL t1_positions: hits=%0d count=%0d required 3 3", hit_pos.size(), match_count);
        end
    endtask

    task automatic test_t2_toggle_valid();
        bit b[$] = '{1, 0, 1, 0, 1, 1, 0, 1};
        run_frame(8'b101, 3, 8, 1, b);
        checks++;
        if (match_count !== 8'd3) begin
            errors++;
            $display("FAIL t2_count: count=%0d required 3", match_count);
        end
    endtask

    task automatic test_t3_cfg_err();
        logic [3:0]  pl[3] = '{4'd0, 4'd9, 4'd3};
        logic [15:0] fr[3] = '{16'd5, 16'd5, 16'd0};
        for (int i = 0; i < 3; i++) begin
            cfg_pattern = 8'h5; cfg_plen = pl[i]; cfg_frame = fr[i]; start = 1'b1;
            step();
            start = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || match_count !== 8'(exp_count)) begin
                errors++;
                $display("FAIL cfg_err_%0d: err=%b in_ready=%b busy=%b count=%0d required 1 0 0 %0d",
                         i, cfg_err, in_ready, busy, match_count, exp_count);
            end
            step();
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_pulse_%0d: err=%b busy=%b required 0 0", i, cfg_err, busy);
            end
        end
    endtask

    task automatic test_t4_saturate();
        bit b[$];
        for (int i = 0; i < 300; i++) b.push_back(1'b1);
        run_frame(8'b1, 1, 300, 0, b);
        checks++;
        if (match_count !== 8'd255) begin
            errors++;
            $display("FAIL t4_saturate: count=%0d required 255", match_count);
        end
    endtask

    task automatic test_t5_start_and_reset();
        bit b[$] = '{1, 0, 1, 0, 1, 1, 0, 1};
        begin_frame(8'b101, 3, 8);
        cfg_pattern = 8'hFF; cfg_plen = 4'd0; cfg_frame = 16'd0; start = 1'b1;
        for (int i = 0; i < 4; i++) feed(b[i], $urandom_range(0, 1));
        start = 1'b0;
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_start_ignored: err=%b busy=%b required 0 1", cfg_err, busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({in_ready, busy, match, done, cfg_err} !== 5'b0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL t5_reset: rdy/busy/match/done/err=%b count=%0d required 00000 0",
                     {in_ready, busy, match, done, cfg_err}, match_count);
        end
        run_frame(8'b101, 3, 8, 0, b);
        checks++;
        if (match_count !== 8'd3) begin
            errors++;
            $display("FAIL t5_rerun: count=%0d required 3", match_count);
        end
    endtask

    task automatic test_t6_short_frame();
        bit b[$] = '{1, 0};
        run_frame(8'b101, 3, 2, 0, b);
        checks++;
        if (match_count !== 8'd0) begin
            errors++;
            $display("FAIL t6_count: count=%0d required 0", match_count);
        end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 25; n++) begin
            bit b[$];
            int plen  = $urandom_range(1, 8);
            int frame = $urandom_range(1, 40);
            logic [7:0] pat = 8'($urandom);
            for (int i = 0; i < frame; i++) b.push_back(1'($urandom));
            run_frame(pat, plen, frame, 2, b);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        test_reset();
        test_t1_back_to_back();
        test_t2_toggle_valid();
        test_t3_cfg_err();
        test_t4_saturate();
        test_t5_start_and_reset();
        test_t6_short_frame();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
